// File: rtl/serv_sleep_ctrl_pkg.sv
// Shared definitions for the SERV WFI sleep controller.
// Holds the sleep FSM state encodings (also used by core and debug logic)
// and a helper that sizes the wake-delay counter.
package serv_sleep_ctrl_pkg;

    // 2-bit encodings kept stable so core and debug views of the state agree.
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;
    localparam logic [1:0] ST_WAKE  = 2'd3;

    // Counter width: enough bits to hold the wake delay, never less than one.
    function automatic int cnt_width(input int delay);
        int w;
        w = $clog2(delay + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serv_sleep_ctrl.sv
// WFI sleep controller with core clock gating, on the free-running i_clk.
// Latency: halt released on the wake cycle (FAST_WAKE=1) or one later; o_wake WAKE_DELAY+1 after wake.
// Backpressure: sleep entry waits for i_bus_idle; requests outside RUN are ignored.
//
// Ports:
//   i_clk, i_rst      free-running clock, synchronous active-high reset
//   i_sleep_req       rising edge requests a sleep entry
//   i_bus_idle        core has no outstanding bus transfer
//   i_irq, i_irq_en   raw interrupt levels and per-source wake enables
//   o_clk_halt        1 = core clock gated
//   o_sleep_ack       high while sleeping
//   o_wake            one-cycle pulse when a sleep episode finishes
//   o_wake_src        enabled interrupts captured at wake, held until next wake
module serv_sleep_ctrl
    import serv_sleep_ctrl_pkg::*;
#(
    parameter           RESET_STRATEGY = "MINI",
    parameter int       NUM_IRQ        = 2,
    parameter int       WAKE_DELAY     = 0,
    parameter bit       FAST_WAKE      = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sleep_req,
    input  logic               i_bus_idle,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_en,
    output logic               o_clk_halt,
    output logic               o_sleep_ack,
    output logic               o_wake,
    output logic [NUM_IRQ-1:0] o_wake_src
);

    localparam int             CW       = cnt_width(WAKE_DELAY);
    localparam logic [CW-1:0]  WAKE_CNT = CW'(WAKE_DELAY);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               halt_q;
    logic               halt_nxt;
    logic               req_q;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic               capture;
    logic [NUM_IRQ-1:0] wake_src;
    logic [NUM_IRQ-1:0] irq_live;
    logic               wake_any;
    logic               start;

    assign irq_live = i_irq & i_irq_en;
    assign wake_any = |irq_live;
    // Only a fresh rising edge starts an entry, so a held request cannot re-enter.
    assign start    = i_sleep_req & ~req_q;

    always_comb begin
        state_nxt = state;
        halt_nxt  = halt_q;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            ST_RUN: begin
                if (start) begin
                    if (wake_any) begin
                        // Interrupt already pending: finish the episode without gating.
                        state_nxt = ST_WAKE;
                        cnt_nxt   = '0;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // A wake beats a simultaneous bus-idle so we never gate needlessly.
                if (wake_any) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else if (i_bus_idle) begin
                    state_nxt = ST_SLEEP;
                    halt_nxt  = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake_any) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = WAKE_CNT;
                    halt_nxt  = 1'b0;
                    capture   = 1'b1;
                end
            end
            ST_WAKE: begin
                // Sticky: interrupt levels are no longer looked at once here.
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_RUN;
            halt_q <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            halt_q <= halt_nxt;
            req_q  <= i_sleep_req;
        end
    end

    // Datapath registers: cleared by reset only under the "MINI" strategy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            if (RESET_STRATEGY == "MINI") begin
                cnt      <= '0;
                wake_src <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            if (capture) begin
                wake_src <= irq_live;
            end
        end
    end

    // FAST_WAKE drops the gate in the same cycle the interrupt is seen; the
    // registered form trades a cycle of latency for a glitch-free gate enable.
    assign o_clk_halt  = FAST_WAKE ? (halt_q & ~wake_any) : halt_q;
    assign o_sleep_ack = (state == ST_SLEEP);
    assign o_wake      = (state == ST_WAKE) && (cnt == '0);
    assign o_wake_src  = wake_src;

endmodule

// File: tb/tb_serv_sleep_ctrl.sv
// Bench for serv_sleep_ctrl: two instances (fast wake / no delay, and
// registered wake / delay 3) driven in lockstep, checked each cycle
// against a time-stamped behavioural model of the sleep episodes.
module tb_serv_sleep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sleep_req = 1'b0;
    logic       bus_idle = 1'b1;
    logic [1:0] irq = 2'b00;
    logic [1:0] irq_en = 2'b00;

    logic       halt_a, ack_a, wake_a;
    logic [1:0] src_a;
    logic       halt_b, ack_b, wake_b;
    logic [1:0] src_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serv_sleep_ctrl #(.RESET_STRATEGY("MINI"), .NUM_IRQ(2), .WAKE_DELAY(0), .FAST_WAKE(1'b1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .i_bus_idle(bus_idle),
        .i_irq(irq), .i_irq_en(irq_en),
        .o_clk_halt(halt_a), .o_sleep_ack(ack_a), .o_wake(wake_a), .o_wake_src(src_a)
    );

    serv_sleep_ctrl #(.RESET_STRATEGY("MINI"), .NUM_IRQ(2), .WAKE_DELAY(3), .FAST_WAKE(1'b0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .i_bus_idle(bus_idle),
        .i_irq(irq), .i_irq_en(irq_en),
        .o_clk_halt(halt_b), .o_sleep_ack(ack_b), .o_wake(wake_b), .o_wake_src(src_b)
    );

    // Model: per configuration, a phase (0 running, 1 draining, 2 asleep,
    // 3 waking), the absolute cycle at which o_wake is due, gate state and
    // captured sources.
    int         cyc = 0;
    bit         m_live = 1'b0;
    bit         m_prev_req = 1'b0;
    int         m_mode [2];
    int         m_wake_at [2];
    bit         m_halted [2];
    logic [1:0] m_src [2];

    function automatic int delay_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic bit fast_of(input int k);
        return (k == 0);
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        bit         any;
        bit         start;
        logic [1:0] live;
        @(negedge clk);
        live = irq & irq_en;
        any  = |live;
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                bit e_halt;
                bit e_ack;
                bit e_wake;
                e_halt = fast_of(k) ? (m_halted[k] && !any) : m_halted[k];
                e_ack  = (m_mode[k] == 2);
                e_wake = (m_mode[k] == 3) && (cyc == m_wake_at[k]);
                chk($sformatf("halt%0d", k), {1'b0, (k == 0) ? halt_a : halt_b}, {1'b0, e_halt});
                chk($sformatf("ack%0d", k),  {1'b0, (k == 0) ? ack_a  : ack_b},  {1'b0, e_ack});
                chk($sformatf("wake%0d", k), {1'b0, (k == 0) ? wake_a : wake_b}, {1'b0, e_wake});
                chk($sformatf("src%0d", k),  (k == 0) ? src_a : src_b, m_src[k]);
            end
        end
        @(posedge clk);
        start = sleep_req && !m_prev_req;
        if (rst) begin
            m_live     = 1'b1;
            m_prev_req = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_mode[k]    = 0;
                m_halted[k]  = 1'b0;
                m_src[k]     = 2'b00;
                m_wake_at[k] = -1;
            end
        end else begin
            m_prev_req = sleep_req;
            for (int k = 0; k < 2; k++) begin
                case (m_mode[k])
                    0: if (start) begin
                        if (any) begin
                            m_mode[k] = 3; m_wake_at[k] = cyc + 1; m_src[k] = live;
                        end else begin
                            m_mode[k] = 1;
                        end
                    end
                    1: if (any) begin
                        m_mode[k] = 3; m_wake_at[k] = cyc + 1; m_src[k] = live;
                    end else if (bus_idle) begin
                        m_mode[k] = 2; m_halted[k] = 1'b1;
                    end
                    2: if (any) begin
                        m_mode[k] = 3; m_wake_at[k] = cyc + 1 + delay_of(k);
                        m_halted[k] = 1'b0; m_src[k] = live;
                    end
                    default: if (cyc == m_wake_at[k]) m_mode[k] = 0;
                endcase
            end
        end
        cyc++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset
        rst = 1'b1; ticks(2);
        rst = 1'b0; ticks(1);
        chk("rst_halt_a", {1'b0, halt_a}, 2'b00);
        chk("rst_wake_b", {1'b0, wake_b}, 2'b00);
        chk("rst_src_a", src_a, 2'b00);

        // 1/2: entry with idle bus, wake on irq[1], drop irq during delayed wake
        irq_en = 2'b10; bus_idle = 1'b1;
        sleep_req = 1'b1; ticks(1);
        sleep_req = 1'b0; ticks(3);
        chk("t1_ack_a", {1'b0, ack_a}, 2'b01);
        chk("t1_halt_b", {1'b0, halt_b}, 2'b01);
        irq = 2'b10; ticks(2);
        irq = 2'b00; ticks(5);
        chk("t1_src_a", src_a, 2'b10);
        chk("t2_src_b", src_b, 2'b10);

        // 3: irq pending at the request edge
        irq_en = 2'b01; irq = 2'b01;
        sleep_req = 1'b1; ticks(1);
        sleep_req = 1'b0; ticks(2);
        irq = 2'b00; ticks(4);
        chk("t3_src_a", src_a, 2'b01);

        // 4: busy bus holds DRAIN; irq arrives with bus idle -> wake wins
        bus_idle = 1'b0; irq_en = 2'b11;
        sleep_req = 1'b1; ticks(1);
        sleep_req = 1'b0; ticks(5);
        bus_idle = 1'b1; irq = 2'b10; ticks(1);
        irq = 2'b00; ticks(5);

        // 5: disabled irq keeps sleeping; reset mid-SLEEP and mid-WAKE
        irq_en = 2'b00;
        sleep_req = 1'b1; ticks(1);
        sleep_req = 1'b0; ticks(3);
        irq = 2'b11; ticks(4);
        chk("t5_halt_a", {1'b0, halt_a}, 2'b01);
        rst = 1'b1; ticks(1);
        rst = 1'b0; irq = 2'b00; ticks(2);
        irq_en = 2'b01;
        sleep_req = 1'b1; ticks(1);
        sleep_req = 1'b0; ticks(3);
        irq = 2'b01; ticks(2);
        rst = 1'b1; irq = 2'b00; ticks(1);
        rst = 1'b0; ticks(5);

        // 6: request held high across a wake, then a fresh edge
        irq_en = 2'b10;
        sleep_req = 1'b1; ticks(3);
        irq = 2'b10; ticks(1);
        irq = 2'b00; ticks(8);
        chk("t6_ack_a", {1'b0, ack_a}, 2'b00);
        sleep_req = 1'b0; ticks(1);
        sleep_req = 1'b1; ticks(4);
        irq = 2'b10; ticks(1);
        irq = 2'b00; sleep_req = 1'b0; ticks(6);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 3) == 0) sleep_req = ~sleep_req;
            bus_idle = ($urandom_range(0, 2) != 0);
            irq = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 15) == 0) irq_en = 2'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
